scan_onehot_driver: RTL and testbench
=====================================

Name: scan_onehot_driver

Overview:
Parametrised successor to the team's 3-to-8 active-low decoder enable block. It drives N_OUT active-low one-hot select lines, such as LED or 7-seg digit commons, in one of two modes. In direct mode a registered decode of data_in drives the lines. In scan mode an internal prescaled counter steps the active line automatically. The block sits between the display/control logic and the pad drivers, and all outputs are registered.

Parameters:
N_OUT, 8, number of select lines (2..256).
SEL_W, $clog2(N_OUT), width of data_in/cur_sel.
DWELL, 1000, clock cycles each position stays active in scan mode (>=1).
DIV_W, 16, prescaler width; DWELL must be <= 2**DIV_W.
GAP, 2, blank cycles between positions (used only with BLANK_GAP_EN, >=1).

Ports:
clk  input  1  single clock, all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
enable  input  1  1 = drive selects; 0 = all lines inactive (high).
mode  input  1  0 = direct decode, 1 = auto scan.
data_in  input  SEL_W  selected line in direct mode.
data_out  output  N_OUT  active-low one-hot select; all ones = none active.
cur_sel  output  SEL_W  index currently driven (or last driven).
frame_done  output  1  one-cycle pulse when scan wraps to position 0.

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst_n` is synchronous, active-low, sampled on the rising edge. While rst_n=0: data_out all ones, cur_sel=0, frame_done=0, prescaler=0, state=IDLE.
- Latency: all outputs are registered, with 1 cycle from input change to output.
- enable=0: data_out = all ones on the next edge. cur_sel holds, prescaler clears to 0, frame_done=0, state=IDLE.
- Direct mode (enable=1, mode=0):
  - data_out = ~(1<<data_in) and cur_sel = data_in on the next edge.
  - data_in >= N_OUT (non-power-of-2 N_OUT) gives data_out all ones and cur_sel unchanged. X is never driven.
  - Prescaler is held at 0.
- Scan mode (enable=1, mode=1), FSM IDLE -> DWELL (-> GAP with feature):
  - IDLE -> DWELL: on the first enabled scan cycle, drive cur_sel with prescaler=0.
  - DWELL: prescaler increments each cycle. At prescaler==DWELL-1 it clears and the position advances to cur_sel==N_OUT-1 ? 0 : cur_sel+1. Wrap uses explicit compare, never natural overflow.
  - frame_done = 1 for exactly the cycle whose data_out first shows position 0 after a wrap. It does not pulse on initial entry.
  - DWELL=1 advances every cycle.
- Mode change mid-dwell: the new mode takes effect on the next edge and the prescaler clears. Direct-to-scan resumes scanning from the current cur_sel.
- Simultaneous events: rst_n=0 has priority over everything, then enable=0, then mode.
- Reset asserted mid-scan forces all reset values on that edge; scanning restarts at position 0.

Optional Feature:
BLANK_GAP_EN
- Defined: after each DWELL period the FSM enters GAP for GAP cycles with data_out all ones and cur_sel showing the next index, then returns to DWELL. frame_done pulses on the first DWELL cycle of position 0. Scan frame period = N_OUT*(DWELL+GAP).
- Undefined: the GAP state and GAP logic are absent. Positions switch back-to-back, and frame period = N_OUT*DWELL.

Decomposition:
- Package scan_drv_pkg:
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1;
  - state enum {ST_IDLE, ST_DWELL, ST_GAP};
  - function onehot_n(sel, n) returning active-low one-hot.
- Sub-module onehot_n_dec: combinational parametrised active-low decoder with a range check (out-of-range gives all ones). It is instantiated once, feeding the data_out register.

Test Plan (N_OUT=8, DWELL=4 unless noted):
1. rst_n=0 for 2 cycles with enable=1, mode=1 -> data_out=8'hFF, cur_sel=0, frame_done=0 throughout.
2. Direct mode, enable=1, data_in=5 -> next cycle data_out=8'b11011111, cur_sel=5. Then enable=0 -> 8'hFF next cycle, cur_sel stays 5.
3. Scan mode from reset -> data_out FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles. It then wraps to FE with frame_done high for that one cycle; frame_done period is 32 cycles.
4. Scan, drop enable on cycle 2 of position 3 -> FF next cycle. Re-enable -> F7 held a full 4 cycles, then EF.
5. N_OUT=5: direct data_in=6 -> 5'b11111. Scan wraps 4->0 with frame period 20 cycles.
6. BLANK_GAP_EN, GAP=2 -> FE x4, FF x2, FD x4, FF x2, ...; frame_done period 48 cycles. rst_n=0 during a GAP -> FF, cur_sel=0 next edge.

Source files
------------

// File: rtl/scan_drv_pkg.sv
// Shared types, mode encodings and the active-low one-hot helper for scan_onehot_driver.
package scan_drv_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned MAX_OUT = 256;
  localparam int unsigned MAX_SEL = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_GAP
  } state_e;

  // Active-low one-hot of sel over n lines; out-of-range sel yields all ones.
  function automatic logic [MAX_OUT-1:0] onehot_n(input logic [MAX_SEL-1:0] sel,
                                                  input int unsigned n);
    logic [MAX_OUT-1:0] v;
    v = '1;
    if (32'(sel) < n) v[sel] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/onehot_n_dec.sv
// Combinational parametrised active-low decoder; out-of-range select gives all ones.
module onehot_n_dec
  import scan_drv_pkg::*;
#(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_OUT-1:0] o_dec_c
);

  assign o_dec_c = N_OUT'(onehot_n(MAX_SEL'(i_sel), N_OUT));

endmodule

// File: rtl/scan_onehot_driver.sv
// Active-low one-hot select driver with direct decode and prescaled auto-scan.
// Define BLANK_GAP_EN to insert GAP blank cycles between scan positions.
module scan_onehot_driver
  import scan_drv_pkg::*;
#(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned SEL_W = $clog2(N_OUT),
  parameter int unsigned DWELL = 1000,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [SEL_W-1:0] data_in,
  output logic [N_OUT-1:0] data_out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             frame_done
);

  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_OUT - 1);
  localparam bit CFG_OK = (N_OUT >= 2) && (N_OUT <= MAX_OUT) && (DWELL >= 1) &&
                          (GAP >= 1) && (64'(DWELL) <= (64'(1) << DIV_W));
`ifdef BLANK_GAP_EN
  localparam logic [DIV_W-1:0] GAP_LAST   = DIV_W'(GAP - 1);
`endif

  if (!CFG_OK) begin : g_bad_cfg
    $error("scan_onehot_driver: illegal parameter combination");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DIV_W-1:0]   r_presc;
  logic [DIV_W-1:0]   w_presc_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [SEL_W-1:0]   w_sel_adv;
  logic [SEL_W-1:0]   w_dec_sel;
  logic [N_OUT-1:0]   w_dec;
  logic [N_OUT-1:0]   r_data_out;
  logic               r_frame_done;
  logic               w_frame_nxt;
  logic               w_blank;
  logic               w_in_range;

  // Explicit wrap so non-power-of-two N_OUT never walks into unused codes.
  assign w_sel_adv  = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
  assign w_in_range = (32'(data_in) < N_OUT);

  onehot_n_dec #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_dec (
    .i_sel   (w_dec_sel),
    .o_dec_c (w_dec)
  );

  // Next-state and next-output selection; priority is enable, then mode.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_sel_nxt   = r_sel;
    w_dec_sel   = r_sel;
    w_blank     = 1'b0;
    w_frame_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_blank     = 1'b1;
    end else if (mode == MODE_DIRECT) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_dec_sel   = data_in;
      if (w_in_range) w_sel_nxt = data_in;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DWELL;
          w_presc_nxt = '0;
        end
        ST_DWELL: begin
          if (r_presc == DWELL_LAST) begin
            w_presc_nxt = '0;
            w_sel_nxt   = w_sel_adv;
`ifdef BLANK_GAP_EN
            w_state_nxt = ST_GAP;
            w_blank     = 1'b1;
`else
            w_dec_sel   = w_sel_adv;
            w_frame_nxt = (w_sel_adv == '0);
`endif
          end else begin
            w_presc_nxt = r_presc + DIV_W'(1);
          end
        end
`ifdef BLANK_GAP_EN
        ST_GAP: begin
          if (r_presc == GAP_LAST) begin
            w_state_nxt = ST_DWELL;
            w_presc_nxt = '0;
            w_frame_nxt = (r_sel == '0);
          end else begin
            w_presc_nxt = r_presc + DIV_W'(1);
            w_blank     = 1'b1;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_presc_nxt = '0;
          w_blank     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_sel        <= '0;
      r_data_out   <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_sel        <= w_sel_nxt;
      r_data_out   <= w_blank ? '1 : w_dec;
      r_frame_done <= w_frame_nxt;
    end
  end

  assign data_out   = r_data_out;
  assign cur_sel    = r_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_onehot_driver.sv
// Directed bench for scan_onehot_driver (N_OUT=8 and N_OUT=5, DWELL=4).
module tb_scan_onehot_driver;

  localparam int DW = 4;
`ifdef BLANK_GAP_EN
  localparam int GP = 2;
`else
  localparam int GP = 0;
`endif
  localparam int P = DW + GP;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       mode;
  logic [2:0] din8;
  logic [2:0] din5;
  logic [7:0] dout8;
  logic [2:0] sel8;
  logic       fd8;
  logic [4:0] dout5;
  logic [2:0] sel5;
  logic       fd5;

  int checks;
  int errors;

  scan_onehot_driver #(.N_OUT(8), .SEL_W(3), .DWELL(DW), .DIV_W(16), .GAP(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .data_in(din8),
    .data_out(dout8), .cur_sel(sel8), .frame_done(fd8)
  );

  scan_onehot_driver #(.N_OUT(5), .SEL_W(3), .DWELL(DW), .DIV_W(16), .GAP(2)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .data_in(din5),
    .data_out(dout5), .cur_sel(sel5), .frame_done(fd5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected scan outputs k cycles after scan entry at position 0 over n lines.
  function automatic void scan_exp(input int k, input int n, output logic [7:0] d,
                                   output int s, output logic f);
    int idx;
    int ph;
    logic [7:0] one;
    logic [7:0] nmask;
    idx   = k / P;
    ph    = k % P;
    nmask = (8'(1) << n) - 8'(1);
    if (n == 8) nmask = 8'hFF;
    one   = 8'(1) << (idx % n);
    if (ph < DW) begin
      d = ~one & nmask;
      s = idx % n;
    end else begin
      d = nmask;
      s = (idx + 1) % n;
    end
    f = (k > 0) && (k % (n * P) == 0);
  endfunction

  initial begin
    logic [7:0] ed;
    int         es;
    logic       ef;
    bit         found;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 1'b1;
    din8   = 3'd0;
    din5   = 3'd0;

    // Reset held with scan requested
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_dout", 32'(dout8), 32'hFF);
      chk("rst_sel", 32'(sel8), 32'd0);
      chk("rst_fd", 32'(fd8), 32'd0);
    end

    // Direct decode and disable
    rst_n = 1'b1; mode = 1'b0; din8 = 3'd5;
    tick();
    chk("dir5_dout", 32'(dout8), 32'hDF);
    chk("dir5_sel", 32'(sel8), 32'd5);
    enable = 1'b0;
    tick();
    chk("dis_dout", 32'(dout8), 32'hFF);
    chk("dis_sel", 32'(sel8), 32'd5);
    enable = 1'b1; din8 = 3'd0;
    tick();
    chk("dir0_dout", 32'(dout8), 32'hFE);
    chk("dir0_sel", 32'(sel8), 32'd0);

    // Scan from reset over more than two frames
    rst_n = 1'b0; mode = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      scan_exp(k, 8, ed, es, ef);
      chk("scan8_dout", 32'(dout8), 32'(ed));
      chk("scan8_sel", 32'(sel8), 32'(es));
      chk("scan8_fd", 32'(fd8), 32'(ef));
    end

    // Reset mid-scan
    rst_n = 1'b0;
    tick();
    chk("midrst_dout", 32'(dout8), 32'hFF);
    chk("midrst_sel", 32'(sel8), 32'd0);
    chk("midrst_fd", 32'(fd8), 32'd0);
    rst_n = 1'b1;

    // Drop enable on cycle 2 of position 3, then re-enable
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (dout8 === 8'hF7) found = 1'b1;
    end
    chk("find_pos3", 32'(found), 32'd1);
    tick();
    chk("pos3_c2", 32'(dout8), 32'hF7);
    enable = 1'b0;
    tick();
    chk("pos3_off_dout", 32'(dout8), 32'hFF);
    chk("pos3_off_sel", 32'(sel8), 32'd3);
    enable = 1'b1;
    for (int i = 0; i < DW; i++) begin
      tick();
      chk("pos3_resume", 32'(dout8), 32'hF7);
    end
    tick();
    chk("pos4_dout", 32'(dout8), (GP > 0) ? 32'hFF : 32'hEF);
    chk("pos4_sel", 32'(sel8), 32'd4);

    // Direct-to-scan resumes at current index, then wraps with frame_done
    mode = 1'b0; din8 = 3'd6;
    tick();
    chk("d2s_dir_dout", 32'(dout8), 32'hBF);
    mode = 1'b1;
    for (int i = 0; i < DW; i++) begin
      tick();
      chk("d2s_pos6", 32'(dout8), 32'hBF);
      chk("d2s_pos6_sel", 32'(sel8), 32'd6);
    end
    for (int i = 0; i < GP; i++) begin
      tick();
      chk("d2s_gap67", 32'(dout8), 32'hFF);
      chk("d2s_gap67_sel", 32'(sel8), 32'd7);
    end
    for (int i = 0; i < DW; i++) begin
      tick();
      chk("d2s_pos7", 32'(dout8), 32'h7F);
      chk("d2s_pos7_fd", 32'(fd8), 32'd0);
    end
    for (int i = 0; i < GP; i++) begin
      tick();
      chk("d2s_gap70", 32'(dout8), 32'hFF);
      chk("d2s_gap70_sel", 32'(sel8), 32'd0);
    end
    tick();
    chk("d2s_wrap_dout", 32'(dout8), 32'hFE);
    chk("d2s_wrap_fd", 32'(fd8), 32'd1);
    tick();
    chk("d2s_wrap_fd_clr", 32'(fd8), 32'd0);

    // N_OUT=5: direct range check
    rst_n = 1'b0; mode = 1'b0; din5 = 3'd2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("n5_dir2_dout", 32'(dout5), 32'h1B);
    chk("n5_dir2_sel", 32'(sel5), 32'd2);
    din5 = 3'd6;
    tick();
    chk("n5_dir6_dout", 32'(dout5), 32'h1F);
    chk("n5_dir6_sel", 32'(sel5), 32'd2);
    din5 = 3'd4;
    tick();
    chk("n5_dir4_dout", 32'(dout5), 32'h0F);
    chk("n5_dir4_sel", 32'(sel5), 32'd4);

    // N_OUT=5: scan wraps 4->0
    rst_n = 1'b0; mode = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      scan_exp(k, 5, ed, es, ef);
      chk("scan5_dout", 32'(dout5), 32'(ed[4:0]));
      chk("scan5_sel", 32'(sel5), 32'(es));
      chk("scan5_fd", 32'(fd5), 32'(ef));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
